// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32 five-stage core, with load-use hazard bubbles, flush and hold.
// Optional hazard-bubble counter on output bubble_cnt when IDEX_BUBBLE_CNT_EN is defined.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic            id_branch,
  input  logic            id_mem_read,
  input  logic            id_memto_reg,
  input  logic            id_mem_write,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic [1:0]      id_alu_op,
  input  logic            flush,
  input  logic            stall_ext,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [RA_W-1:0] ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_branch,
  output logic            ex_mem_read,
  output logic            ex_memto_reg,
  output logic            ex_mem_write,
  output logic            ex_alu_src,
  output logic            ex_reg_write,
  output logic [1:0]      ex_alu_op,
  output logic            hazard_stall
`ifdef IDEX_BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  logic rs1_dep, rs2_dep;
  logic load_en, kill_ctl;

  // Load-use detection against the registered EX slot; x0 is never a real destination.
  assign rs1_dep      = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_dep      = id_uses_rs2 && (id_rs2 == ex_rd);
  assign hazard_stall = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) && (rs1_dep || rs2_dep);

  // flush overrides the downstream hold; any bubble source zeroes the control bundle.
  assign load_en  = flush || !stall_ext;
  assign kill_ctl = flush || hazard_stall || !id_valid;

  // EX stage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_funct3    <= '0;
      ex_funct7b5  <= 1'b0;
      ex_branch    <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_memto_reg <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_src   <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_alu_op    <= '0;
    end else if (load_en) begin
      ex_valid     <= !kill_ctl;
      ex_pc        <= id_pc;
      ex_rs1_data  <= id_rs1_data;
      ex_rs2_data  <= id_rs2_data;
      ex_imm       <= id_imm;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_funct3    <= id_funct3;
      ex_funct7b5  <= id_funct7b5;
      ex_branch    <= id_branch    && !kill_ctl;
      ex_mem_read  <= id_mem_read  && !kill_ctl;
      ex_memto_reg <= id_memto_reg && !kill_ctl;
      ex_mem_write <= id_mem_write && !kill_ctl;
      ex_alu_src   <= id_alu_src   && !kill_ctl;
      ex_reg_write <= id_reg_write && !kill_ctl;
      ex_alu_op    <= kill_ctl ? 2'b00 : id_alu_op;
    end
  end

`ifdef IDEX_BUBBLE_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Counts only bubbles taken for a load-use hazard, never flushes or held cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bubble_cnt <= '0;
    else if (!flush && !stall_ext && hazard_stall)
      bubble_cnt <= sat_inc(bubble_cnt);
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand sequences and a random run against a rule-level model.
module tb_id_ex_stage;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic        br, mr, m2r, mw, as, rw;
    logic [1:0]  aluop;
  } ex_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [2:0]  f3;
    logic        f7;
    logic        br, mr, m2r, mw, as, rw;
    logic [1:0]  aluop;
    logic        flush, stall;
  } in_t;

  typedef struct {
    in_t         i;
    logic        haz;
    logic        valid;
    logic [31:0] pc;
    logic        rw;
    logic [1:0]  aluop;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_uses_rs1, id_uses_rs2, id_funct7b5;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_funct3;
  logic id_branch, id_mem_read, id_memto_reg, id_mem_write, id_alu_src, id_reg_write;
  logic [1:0] id_alu_op;
  logic flush, stall_ext;
  logic ex_valid, ex_funct7b5;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic ex_branch, ex_mem_read, ex_memto_reg, ex_mem_write, ex_alu_src, ex_reg_write;
  logic [1:0] ex_alu_op;
  logic hazard_stall;
`ifdef IDEX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_cnt;
`endif

  id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_branch(id_branch), .id_mem_read(id_mem_read), .id_memto_reg(id_memto_reg),
    .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_alu_op(id_alu_op), .flush(flush), .stall_ext(stall_ext),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_branch(ex_branch),
    .ex_mem_read(ex_mem_read), .ex_memto_reg(ex_memto_reg), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
    .hazard_stall(hazard_stall)
`ifdef IDEX_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  ex_t act;
  assign act = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                ex_funct3, ex_funct7b5, ex_branch, ex_mem_read, ex_memto_reg, ex_mem_write,
                ex_alu_src, ex_reg_write, ex_alu_op};

  int n_chk = 0;
  int n_pass = 0;
  ex_t m;
  logic [CNT_W-1:0] cnt_m;

  task automatic chk(input string nm, input logic [159:0] a, input logic [159:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  // Reference rules: a load in EX blocks any valid reader of its non-zero destination.
  function automatic logic model_haz(input ex_t e, input in_t i);
    logic dep;
    dep = (i.u1 && i.rs1 == e.rd) || (i.u2 && i.rs2 == e.rd);
    return i.valid && e.valid && e.mr && (e.rd != 5'd0) && dep;
  endfunction

  function automatic ex_t model_next(input ex_t e, input in_t i);
    ex_t n;
    if (i.stall && !i.flush) return e;
    n = '0;
    n.pc = i.pc; n.rs1d = i.rs1d; n.rs2d = i.rs2d; n.imm = i.imm;
    n.rs1 = i.rs1; n.rs2 = i.rs2; n.rd = i.rd; n.f3 = i.f3; n.f7 = i.f7;
    if (!(i.flush || model_haz(e, i) || !i.valid)) begin
      n.valid = 1'b1;
      n.br = i.br; n.mr = i.mr; n.m2r = i.m2r; n.mw = i.mw;
      n.as = i.as; n.rw = i.rw; n.aluop = i.aluop;
    end
    return n;
  endfunction

  function automatic in_t mk(input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                             input logic u1, u2, mr, rw, input logic [1:0] aluop,
                             input logic fl, st);
    in_t i;
    i = '0;
    i.valid = v; i.pc = pc; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
    i.u1 = u1; i.u2 = u2; i.mr = mr; i.m2r = mr; i.as = mr; i.rw = rw; i.aluop = aluop;
    i.f3 = mr ? 3'b010 : 3'b000;
    i.rs1d = pc ^ 32'h1111_0000; i.rs2d = pc ^ 32'h2222_0000; i.imm = pc + 32'd4;
    i.flush = fl; i.stall = st;
    return i;
  endfunction

  function automatic in_t rand_in();
    in_t i;
    i.valid = ($urandom_range(0, 7) != 0);
    i.pc = $urandom(); i.rs1d = $urandom(); i.rs2d = $urandom(); i.imm = $urandom();
    i.rs1 = 5'($urandom_range(0, 3)); i.rs2 = 5'($urandom_range(0, 3));
    i.rd = 5'($urandom_range(0, 3));
    i.u1 = 1'($urandom()); i.u2 = 1'($urandom());
    i.f3 = 3'($urandom()); i.f7 = 1'($urandom());
    i.br = 1'($urandom()); i.mr = 1'($urandom()); i.m2r = 1'($urandom());
    i.mw = 1'($urandom()); i.as = 1'($urandom()); i.rw = 1'($urandom());
    i.aluop = 2'($urandom());
    i.flush = ($urandom_range(0, 7) == 0);
    i.stall = ($urandom_range(0, 5) == 0);
    return i;
  endfunction

  task automatic drive(input in_t i);
    id_valid = i.valid; id_pc = i.pc; id_rs1_data = i.rs1d; id_rs2_data = i.rs2d; id_imm = i.imm;
    id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd; id_uses_rs1 = i.u1; id_uses_rs2 = i.u2;
    id_funct3 = i.f3; id_funct7b5 = i.f7; id_branch = i.br; id_mem_read = i.mr;
    id_memto_reg = i.m2r; id_mem_write = i.mw; id_alu_src = i.as; id_reg_write = i.rw;
    id_alu_op = i.aluop; flush = i.flush; stall_ext = i.stall;
  endtask

  // Entered one time unit after a rising edge; leaves one time unit after the next.
  task automatic cycle(input in_t i, output logic haz_seen);
    logic hz;
    drive(i);
    #1;
    hz = model_haz(m, i);
    haz_seen = hazard_stall;
    chk("hazard_stall", 160'(hazard_stall), 160'(hz));
    if (!i.flush && !i.stall && hz && cnt_m != CNT_MAX) cnt_m = cnt_m + 1'b1;
    m = model_next(m, i);
    @(posedge clk);
    #1;
    chk("ex_bundle", 160'(act), 160'(m));
`ifdef IDEX_BUBBLE_CNT_EN
    chk("bubble_cnt", 160'(bubble_cnt), 160'(cnt_m));
`endif
  endtask

  vec_t tbl[10];
  logic hs;
  ex_t snap;
  in_t cur;

  initial begin
    tbl[0] = '{mk(1, 32'h100, 2, 0, 5, 1, 0, 1, 1, 2'b00, 0, 0), 0, 1, 32'h100, 1, 2'b00};
    tbl[1] = '{mk(1, 32'h104, 3, 5, 6, 1, 1, 0, 1, 2'b10, 0, 0), 1, 0, 32'h104, 0, 2'b00};
    tbl[2] = '{mk(1, 32'h104, 3, 5, 6, 1, 1, 0, 1, 2'b10, 0, 0), 0, 1, 32'h104, 1, 2'b10};
    tbl[3] = '{mk(1, 32'h108, 2, 0, 0, 1, 0, 1, 1, 2'b00, 0, 0), 0, 1, 32'h108, 1, 2'b00};
    tbl[4] = '{mk(1, 32'h10c, 0, 4, 9, 1, 1, 0, 1, 2'b10, 0, 0), 0, 1, 32'h10c, 1, 2'b10};
    tbl[5] = '{mk(1, 32'h110, 2, 0, 7, 1, 0, 1, 1, 2'b00, 0, 0), 0, 1, 32'h110, 1, 2'b00};
    tbl[6] = '{mk(1, 32'h114, 1, 7, 9, 1, 0, 0, 1, 2'b10, 0, 0), 0, 1, 32'h114, 1, 2'b10};
    tbl[7] = '{mk(1, 32'h118, 2, 0, 8, 1, 0, 1, 1, 2'b00, 0, 0), 0, 1, 32'h118, 1, 2'b00};
    tbl[8] = '{mk(1, 32'h11c, 8, 0, 9, 1, 0, 0, 1, 2'b10, 1, 0), 1, 0, 32'h11c, 0, 2'b00};
    tbl[9] = '{mk(0, 32'h120, 1, 2, 9, 1, 1, 0, 1, 2'b10, 0, 0), 0, 0, 32'h120, 0, 2'b00};

    // Reset held low with random decode inputs
    rst_n = 1'b0;
    m = '0;
    cnt_m = '0;
    for (int k = 0; k < 3; k++) begin
      drive(rand_in());
      @(posedge clk);
      #1;
      chk("reset_ex", 160'(act), 160'(0));
    end
    rst_n = 1'b1;
    cycle(mk(1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), hs);
    chk("first_pc", 160'(ex_pc), 160'(32'h40));
    chk("first_valid", 160'(ex_valid), 160'(1));

    // Directed vector table
    for (int k = 0; k < 10; k++) begin
      cycle(tbl[k].i, hs);
      chk($sformatf("tbl%0d_haz", k), 160'(hs), 160'(tbl[k].haz));
      chk($sformatf("tbl%0d_valid", k), 160'(ex_valid), 160'(tbl[k].valid));
      chk($sformatf("tbl%0d_pc", k), 160'(ex_pc), 160'(tbl[k].pc));
      chk($sformatf("tbl%0d_rw", k), 160'(ex_reg_write), 160'(tbl[k].rw));
      chk($sformatf("tbl%0d_aluop", k), 160'(ex_alu_op), 160'(tbl[k].aluop));
`ifdef IDEX_BUBBLE_CNT_EN
      if (k == 2 || k == 9) chk("tbl_bubble_cnt", 160'(bubble_cnt), 160'(1));
`endif
    end

    // Downstream hold: three stalled cycles with changing inputs, then release
    cycle(mk(1, 32'h200, 1, 2, 3, 1, 1, 0, 1, 2'b10, 0, 0), hs);
    snap = act;
    for (int k = 0; k < 3; k++) begin
      cur = rand_in();
      cur.flush = 1'b0;
      cur.stall = 1'b1;
      cycle(cur, hs);
      chk("stall_hold", 160'(act), 160'(snap));
    end
    cur = mk(1, 32'h300, 1, 2, 3, 1, 1, 0, 1, 2'b01, 0, 0);
    cycle(cur, hs);
    chk("stall_release_pc", 160'(ex_pc), 160'(32'h300));
    chk("stall_release_op", 160'(ex_alu_op), 160'(2'b01));

    // Hold and hazard together: the request stays up while the register is frozen
    cycle(mk(1, 32'h400, 1, 0, 5, 1, 0, 1, 1, 2'b00, 0, 0), hs);
    cycle(mk(1, 32'h404, 5, 0, 6, 1, 0, 0, 1, 2'b10, 0, 1), hs);
    chk("stall_haz_a", 160'(hs), 160'(1));
    chk("stall_haz_pc", 160'(ex_pc), 160'(32'h400));
    cycle(mk(1, 32'h404, 5, 0, 6, 1, 0, 0, 1, 2'b10, 0, 0), hs);
    chk("stall_haz_b", 160'(hs), 160'(1));
    chk("stall_haz_bubble", 160'(ex_valid), 160'(0));
    cycle(mk(1, 32'h404, 5, 0, 6, 1, 0, 0, 1, 2'b10, 0, 0), hs);
    chk("stall_haz_c", 160'(hs), 160'(0));
    chk("stall_haz_dep", 160'(ex_valid), 160'(1));

    // Randomised run against the model
    for (int k = 0; k < 300; k++) cycle(rand_in(), hs);

    // Asynchronous reset mid-operation
    cycle(mk(1, 32'h500, 1, 0, 5, 1, 0, 1, 1, 2'b00, 0, 0), hs);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 160'(act), 160'(0));
    m = '0;
    cnt_m = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(mk(1, 32'h44, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0), hs);
    chk("post_reset_pc", 160'(ex_pc), 160'(32'h44));

`ifdef IDEX_BUBBLE_CNT_EN
    // Counter saturation: 21 load-use pairs into a 4-bit counter
    for (int k = 0; k < 21; k++) begin
      cycle(mk(1, 32'h600 + 32'(k * 8), 1, 0, 6, 1, 0, 1, 1, 2'b00, 0, 0), hs);
      cycle(mk(1, 32'h604 + 32'(k * 8), 6, 0, 7, 1, 0, 0, 1, 2'b10, 0, 0), hs);
      if (k == 19) chk("sat_20", 160'(bubble_cnt), 160'(15));
    end
    chk("sat_held", 160'(bubble_cnt), 160'(15));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode/execute pipeline register for the RV32 five-stage core. It sits directly downstream of the opcode control decoder and captures that decoder's control bundle (Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp) together with the decoded operands. It also contains load-use hazard detection: it inserts one-cycle bubbles, honours branch flushes and holds on downstream stalls.

## Interface
- XLEN, 32, datapath width
- RA_W, 5, register-address width
- CNT_W, 16, bubble-counter width (used only with the macro in Configuration)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- id_valid  in  1  decode slot holds a real instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decoded operands
- id_rs1, id_rs2, id_rd  in  RA_W each  register addresses
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads the register
- id_funct3  in  3; id_funct7b5  in  1  ALU-control fields
- id_branch, id_mem_read, id_memto_reg, id_mem_write, id_alu_src, id_reg_write  in  1 each  control bundle from decoder
- id_alu_op  in  2  ALUOp from decoder
- flush  in  1  branch/jump resolved taken; kill decode slot
- stall_ext  in  1  downstream stall; hold EX register
- ex_valid  out  1  EX slot holds a real instruction
- ex_* (pc, rs1_data, rs2_data, imm, rs1, rs2, rd, funct3, funct7b5, branch, mem_read, memto_reg, mem_write, alu_src, reg_write, alu_op)  out  same widths as id_*  registered copies
- hazard_stall  out  1  combinational; freeze PC and IF/ID register
- bubble_cnt  out  CNT_W  hazard-bubble count (only when the macro is defined)

## Operation
- hazard_stall = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Per-edge priority, highest first:
  1. **Reset:** all ex_* = 0, ex_valid = 0.
  2. **flush:** load a bubble.
  3. **stall_ext:** every ex_* holds, including ex_valid.
  4. **hazard_stall:** load a bubble.
  5. **Normal:** capture all id_* fields; ex_valid = id_valid.
- Bubble: ex_valid = 0 and all seven control outputs = 0. Data and address fields capture id_* as usual; they are don't-care in content but must be deterministic.
- Invariant: any control output can be 1 only when ex_valid = 1. When id_valid = 0 in the normal case, the controls load 0.
- Address x0 never causes a hazard.
- No arithmetic on the datapath. The only arithmetic is the optional counter, which saturates.

## Timing
- One-cycle latency from id_* to ex_*.
- A load-use dependency costs exactly one bubble:
  - hazard_stall is high in cycle N.
  - The bubble appears in EX in cycle N+1, so hazard_stall is low in N+1.
  - The dependent instruction reaches EX in cycle N+2.
- hazard_stall is combinational from the registered EX state and the id_* inputs. There is no registered output delay.
- Simultaneous events:
  - flush with hazard_stall: flush wins, and the cycle is not counted as a hazard bubble.
  - stall_ext with hazard_stall: the register holds, and hazard_stall stays asserted for the upstream stages.
- Reset mid-operation: outputs clear immediately on rst_n low. The first capture happens on the first rising edge after rst_n deasserts.

## Configuration
- Macro: IDEX_BUBBLE_CNT_EN.
- **Defined:**
  - bubble_cnt port exists.
  - Reset value is 0.
  - It increments on each edge where priority case 4 (hazard bubble) is taken.
  - It saturates at 2^CNT_W−1.
- **Undefined:** the port and counter logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst_n low with random id_* → every ex_* = 0 and ex_valid = 0. After release, id_valid=1 and id_pc=0x40 → ex_pc=0x40 and ex_valid=1 one edge later.
- Load-use: EX holds lw (mem_read=1, rd=5); ID has add with rs2=5, uses_rs2=1 → hazard_stall=1.
  - Next edge: ex_valid=0, controls 0, hazard_stall=0.
  - Following edge: add in EX with reg_write=1, alu_op=2'b10.
  - bubble_cnt=1.
- x0 and unused operand:
  - EX lw with rd=0 and ID rs1=0 → hazard_stall=0.
  - EX lw with rd=7 and ID rs2=7 but uses_rs2=0 → hazard_stall=0.
- Flush priority: hazard condition true with flush=1 → bubble loaded and bubble_cnt unchanged.
- stall_ext: three cycles with stall_ext=1 and changing id_* → ex_* constant. Release → captures the current id_*.
- Saturation (macro on, CNT_W=4): 20 consecutive hazard bubbles → bubble_cnt = 15 and held.
